// File: rtl/ad9910_pkg.sv
// ad9910_pkg: shared state encoding and default field width for the AD9910 timing blocks
package ad9910_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_HIGH, ST_GAP} state_e;
endpackage

// File: rtl/pg_down_counter.sv
// pg_down_counter: loadable down-counter that saturates at zero and flags terminal count
module pg_down_counter
  import ad9910_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] val_i,
  output logic             tc_o
);
  logic [WIDTH-1:0] cnt_q;
  // load wins over decrement; holding at zero keeps tc stable while idle
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign tc_o = cnt_q == '0;
endmodule

// File: rtl/width2pulse_gen.sv
// width2pulse_gen: delayed, repeated pulse train generator driven by programmed widths
module width2pulse_gen
  import ad9910_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] delay_in,
  input  logic [WIDTH-1:0] width_in,
  input  logic [WIDTH-1:0] gap_in,
  input  logic [WIDTH-1:0] repeat_in,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pulse_idx
);
  state_e           state_q;
  logic [WIDTH-1:0] width_q, gap_q, idx_q;
  logic             done_q;
  logic             acc, ph_tc, rep_tc, ph_load_d, rep_en_d;
  logic [WIDTH-1:0] ph_val_d, rep_val_d;
  // phase counter reloads at every phase boundary; repeat counter steps once per finished pulse
  always_comb begin
    acc       = state_q == ST_IDLE && start && !abort && width_in != '0;
    ph_load_d = acc || (!abort && ph_tc && state_q != ST_IDLE && !(state_q == ST_HIGH && rep_tc));
    ph_val_d  = acc ? (delay_in == '0 ? width_in : delay_in) - 1'b1
                    : (state_q == ST_HIGH && gap_q != '0 ? gap_q : width_q) - 1'b1;
    rep_val_d = repeat_in == '0 ? '0 : repeat_in - 1'b1;
    rep_en_d  = !abort && state_q == ST_HIGH && ph_tc;
  end
  pg_down_counter #(.WIDTH(WIDTH)) u_phase (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .load_i(ph_load_d),
    .en_i  (1'b1),
    .val_i (ph_val_d),
    .tc_o  (ph_tc)
  );
  pg_down_counter #(.WIDTH(WIDTH)) u_repeat (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .load_i(acc),
    .en_i  (rep_en_d),
    .val_i (rep_val_d),
    .tc_o  (rep_tc)
  );
  // sequence FSM: latches configuration on start, abort always returns to idle without done
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q <= ST_IDLE;
      width_q <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) state_q <= ST_IDLE;
      else case (state_q)
        ST_IDLE: if (start) begin
          width_q <= width_in;
          gap_q   <= gap_in;
          idx_q   <= '0;
          if (width_in == '0) done_q <= 1'b1;
          else state_q <= delay_in == '0 ? ST_HIGH : ST_DELAY;
        end
        ST_DELAY: if (ph_tc) state_q <= ST_HIGH;
        ST_HIGH: if (ph_tc) begin
          if (rep_tc) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else if (gap_q != '0) state_q <= ST_GAP;
          else idx_q <= idx_q + 1'b1;
        end
        ST_GAP: if (ph_tc) begin
          state_q <= ST_HIGH;
          idx_q   <= idx_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  assign pulse_out = state_q == ST_HIGH;
  assign busy      = state_q != ST_IDLE;
  assign done      = done_q;
  assign pulse_idx = idx_q;
endmodule

// File: tb/tb_width2pulse_gen.sv
// tb_width2pulse_gen: randomized scoreboard bench for the pulse train generator
module tb_width2pulse_gen;
  localparam int W = 16;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [W-1:0] delay_in = '0, width_in = '0, gap_in = '0, repeat_in = '0;
  logic pulse_out, busy, done;
  logic [W-1:0] pulse_idx;

  width2pulse_gen #(.WIDTH(W)) dut (
    .sys_clk(clk), .sys_rst(rst), .start(start), .abort(abort),
    .delay_in(delay_in), .width_in(width_in), .gap_in(gap_in), .repeat_in(repeat_in),
    .pulse_out(pulse_out), .busy(busy), .done(done), .pulse_idx(pulse_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; bit p; bit b; bit dn; int idx;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, last_idx = 0;

  function automatic void chk(string nm, int got, int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, got, want);
    end
  endfunction

  // expected outputs at offset t (1 = cycle after start) from the sequence rules
  function automatic exp_t model(int t, int d, int w, int g, int r);
    exp_t e;
    int l, o;
    e = '{default: 0};
    if (w == 0) begin
      e.dn = 1;
      return e;
    end
    l = d + r * w + (r - 1) * g;
    if (t > l) begin
      e.dn = 1;
      e.idx = r - 1;
    end else if (t > d) begin
      o = t - 1 - d;
      e.b = 1;
      e.idx = o / (w + g);
      e.p = (o % (w + g)) < w;
    end else e.b = 1;
    return e;
  endfunction

  function automatic void push(exp_t e, int c);
    e.cyc = c;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missed_check cycle %0d: got none expected one", q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("pulse_out", int'(pulse_out), int'(e.p));
      chk("busy", int'(busy), int'(e.b));
      chk("done", int'(done), int'(e.dn));
      chk("pulse_idx", int'(pulse_idx), e.idx);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cfg();
    delay_in = W'($urandom);
    width_in = W'($urandom);
    gap_in = W'($urandom);
    repeat_in = W'($urandom);
  endtask

  task automatic idle(int n, bit s, bit a);
    exp_t e;
    e = '{default: 0};
    e.idx = last_idx;
    for (int i = 0; i < n; i++) begin
      push(e, cyc + 1);
      start = s;
      abort = a;
      rnd_cfg();
      step();
    end
    start = 0;
    abort = 0;
  endtask

  // a: abort offset, rs: ignored restart offset, ra: async reset offset (0 = none)
  task automatic run(int d, int w, int g, int r, int a, int rs, int ra);
    exp_t e;
    int k, l, last, rn, npush;
    k = cyc;
    rn = (r == 0) ? 1 : r;
    l = (w == 0) ? 0 : d + rn * w + (rn - 1) * g;
    last = a > 0 ? a : (ra > 0 ? ra : l);
    npush = ra > 0 ? ra - 1 : last;
    delay_in = W'(d);
    width_in = W'(w);
    gap_in = W'(g);
    repeat_in = W'(r);
    start = 1;
    abort = 0;
    for (int t = 1; t <= npush; t++) push(model(t, d, w, g, rn), k + t);
    if (ra == 0) begin
      if (a > 0) begin
        e = model(a, d, w, g, rn);
        e.p = 0;
        e.b = 0;
        e.dn = 0;
      end else e = model(l + 1, d, w, g, rn);
      push(e, k + last + 1);
      last_idx = e.idx;
    end
    for (int t = 1; t <= last; t++) begin
      step();
      start = (t == rs);
      abort = (t == a);
      rnd_cfg();
    end
    if (ra > 0) begin
      #1;
      chk("busy_before_reset", int'(busy), 1);
      #1;
      rst = 1;
      #1;
      chk("rst_pulse_out", int'(pulse_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pulse_idx", int'(pulse_idx), 0);
      last_idx = 0;
      @(negedge clk);
      #1;
      rst = 0;
      step();
    end else step();
    start = 0;
    abort = 0;
  endtask

  initial begin
    int d, w, g, r, l, a, rs, rn;
    repeat (3) step();
    chk("reset_pulse_out", int'(pulse_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_pulse_idx", int'(pulse_idx), 0);
    rst = 0;
    idle(3, 0, 0);
    run(0, 3, 0, 1, 0, 0, 0);
    idle(2, 0, 0);
    run(4, 2, 3, 3, 0, 0, 0);
    run(7, 0, 5, 3, 0, 0, 0);
    idle(1, 0, 0);
    run(0, 2, 0, 2, 0, 2, 0);
    run(1, 1, 1, 2, 0, 0, 0);
    run(0, 100, 0, 1, 5, 0, 0);
    idle(2, 1, 1);
    idle(2, 0, 0);
    run(2, 3, 1, 0, 0, 0, 0);
    run(0, 2, 4, 3, 0, 0, 10);
    idle(3, 0, 0);
    run(1, 65535, 0, 1, 0, 0, 0);
    idle(1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      d = $urandom_range(0, 5);
      w = $urandom_range(0, 6);
      g = $urandom_range(0, 4);
      r = $urandom_range(0, 4);
      rn = (r == 0) ? 1 : r;
      l = (w == 0) ? 0 : d + rn * w + (rn - 1) * g;
      a = (l > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, l) : 0;
      rs = (l > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, l) : 0;
      run(d, w, g, r, a, rs, 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 0, 1'($urandom_range(0, 1)));
    end
    idle(3, 0, 0);
    repeat (3) step();
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/width2pulse_gen.md
Name: width2pulse_gen

Overview:
- Converts programmed widths into a timed pulse train; the inverse of the level-width counter.
- On a start strobe it waits a programmable delay, then emits repeat_in pulses.
- Each pulse is high for width_in cycles, with gap_in low cycles between pulses.
- Sits between the control register bank and AD9910 timing pins (IO_UPDATE, profile and OSK strobes).

Parameters:
WIDTH, 16, bit width of every count and configuration field.

Ports:
sys_clk  in  1  system clock; all logic on rising edge.
sys_rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
abort  in  1  stop immediately, in any state.
delay_in  in  WIDTH  cycles from start to the first rising edge of pulse_out (0 allowed).
width_in  in  WIDTH  high cycles per pulse; 0 means no pulse.
gap_in  in  WIDTH  low cycles between pulses; 0 means back-to-back.
repeat_in  in  WIDTH  number of pulses; 0 treated as 1.
pulse_out  out  1  generated pulse, registered.
busy  out  1  high while a sequence is active.
done  out  1  one-cycle strobe on normal completion.
pulse_idx  out  WIDTH  0-based index of the current or last pulse.

Behaviour:
- Reset: asynchronous on sys_rst high. State IDLE, all counters 0, pulse_out=0, busy=0, done=0, pulse_idx=0.
- Configuration: all *_in values are latched in the cycle start is accepted. Later input changes do not affect a running sequence.
- States:
  - IDLE: pulse_out=0, busy=0.
  - DELAY: counts delay_in cycles.
  - HIGH: pulse_out=1, counts width_in cycles.
  - GAP: pulse_out=0, counts gap_in cycles.
- Outputs are decoded from registered state, so there is no combinational path from inputs to outputs.
- Timing, with start high in cycle k:
  - delay_in=0: cycle k+1 is HIGH.
  - delay_in=D>0: cycles k+1 .. k+D are DELAY, and cycle k+D+1 is the first HIGH.
- Transitions out of HIGH: after W cycles, go to GAP if gap_in>0 and pulses remain; else go to HIGH if pulses remain; else go to IDLE.
  - With gap_in=0 and multiple pulses, pulse_out stays continuously high for repeat*W cycles. pulse_idx still increments every W cycles.
- GAP: after G cycles, go to HIGH and increment pulse_idx.
- Completion: the cycle after the last HIGH cycle is IDLE, with done=1 for exactly that cycle and busy=0.
- busy: high exactly in DELAY, HIGH and GAP.
- width_in=0 at start: no pulse. Cycle k+1 has done=1, busy stays 0, delay is ignored.
- start while busy is ignored, with no restart or re-latch.
- abort in any non-IDLE state: next cycle is IDLE, pulse_out=0, done=0, and pulse_idx keeps its last value.
- abort and start in the same IDLE cycle: abort wins and nothing starts.
- start in the same cycle as done: accepted, because the FSM is in IDLE. The next sequence begins in the following cycle.
- Counters:
  - Down-counters are WIDTH bits, loaded with value-1.
  - pulse_idx never wraps, since it is bounded by repeat_in-1.
  - Full-scale values (2^WIDTH-1) must work without overflow.
- pulse_idx resets to 0 when a new start is accepted.

Decomposition:
- Shared package ad9910_pkg:
  - state enum constants ST_IDLE, ST_DELAY, ST_HIGH, ST_GAP, encoded in 2 bits;
  - default WIDTH=16.
- One sub-module, pg_down_counter: a WIDTH-bit loadable down-counter with a load/enable input and a terminal-count output. It is instantiated for the phase counter and the repeat counter; pulse_idx is a plain incrementer in the top level.

Test Plan:
1. delay=0, width=3, gap=0, repeat=1, start at cycle 10 -> pulse_out high in cycles 11-13, done=1 in cycle 14, busy high in 11-13.
2. delay=4, width=2, gap=3, repeat=3, start at cycle 0 -> pulse_out high in 5-6, 10-11, 15-16; pulse_idx reads 0, 1, 2; done in 17.
3. width=0, start at cycle 0 -> pulse_out never high, done=1 in cycle 1, busy never high.
4. width=2, gap=0, repeat=2 -> pulse_out continuously high for 4 cycles, pulse_idx steps 0 to 1 after 2 cycles. Also: start re-pulsed mid-sequence is ignored and the timing is unchanged.
5. width=100, abort in the 5th HIGH cycle -> pulse_out=0 and busy=0 next cycle, done never asserted. start together with abort in IDLE -> no sequence.
6. sys_rst asserted mid-GAP, asynchronously between clock edges -> all outputs 0 immediately. width=0xFFFF, repeat=1 -> exactly 65535 high cycles, then done.
